// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the commit trace buffer.
//   TRACE_REG / TRACE_MEM : event kind values carried in ev_kind_o
//   IDLE / RUN / DRAIN / DONE : capture state encoding
//   trace_entry_t : entry layout {kind, cycle, addr, data} at the default
//                   sizes (DATA_W=32, MAX_CYCLES=30). The top module builds
//                   the same field order at its parameterised widths.
package trace_pkg;

  localparam logic TRACE_REG = 1'b0;
  localparam logic TRACE_MEM = 1'b1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int unsigned TRACE_DATA_W = 32;
  localparam int unsigned TRACE_CYC_W  = 5;

  typedef struct packed {
    logic                    kind;
    logic [TRACE_CYC_W-1:0]  cycle;
    logic [TRACE_DATA_W-1:0] addr;
    logic [TRACE_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: circular FIFO with two push ports and one pop port.
//   clk, rst        : clock, asynchronous active-high reset
//   push0 / data0   : first push of the edge (written at the tail)
//   push1 / data1   : second push of the edge (written after data0 if both)
//   pop             : remove the head entry
//   head            : head entry (all zeros after reset)
//   count           : number of stored entries, 0..DEPTH
// The caller guarantees pushes never exceed free space and pop only when
// count is non-zero. DEPTH must be a power of two so pointers wrap freely.
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push0,
  input  logic [WIDTH-1:0] data0,
  input  logic             push1,
  input  logic [WIDTH-1:0] data1,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push0) begin
        mem[wr_ptr] <= data0;
      end
      // Second slot lands after the first only when the first was used.
      if (push1) begin
        mem[wr_ptr + PTR_W'(push0)] <= data1;
      end
      wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: snoops register writeback and store ports, stamps each
// architectural update with its cycle number inside a capture window, and
// buffers the events for a valid/ready consumer.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   start_i             : arms capture while idle
//   wb_en_i/addr/data   : register writeback (writes to x0 are ignored)
//   mem_we_i/addr/data  : data-memory store
//   ev_valid_o/ready_i  : output stream handshake
//   ev_kind_o/cycle/addr/data : head event fields
//   busy_o, done_o      : capture or drain in progress / finished
//   drop_cnt_o          : saturating count of events lost to a full FIFO
// Build option: COMMIT_TRACE_MEM_EN enables store capture; without it the
// mem_* inputs are ignored and only register writes are logged.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAX_CYCLES = 30,
  parameter int unsigned CYC_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              wb_en_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              mem_we_i,
  input  logic [DATA_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              ev_valid_o,
  input  logic              ev_ready_i,
  output logic              ev_kind_o,
  output logic [CYC_W-1:0]  ev_cycle_o,
  output logic [DATA_W-1:0] ev_addr_o,
  output logic [DATA_W-1:0] ev_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       drop_cnt_o
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = 1 + CYC_W + 2 * DATA_W;

  typedef struct packed {
    logic              kind;
    logic [CYC_W-1:0]  cycle;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [1:0]       state;
  logic [CYC_W-1:0] cyc;
  logic [15:0]      drop_cnt;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   free;
  entry_t           wb_entry;
  entry_t           first_entry;
  entry_t           second_entry;
  logic [ENTRY_W-1:0] head;
  entry_t           head_entry;
  logic             wb_ev;
  logic             first_ev;
  logic             second_ev;
  logic             push0;
  logic             push1;
  logic             pop;
  logic [1:0]       drops;
  logic [16:0]      drop_sum;

`ifdef COMMIT_TRACE_MEM_EN
  entry_t mem_entry;
  logic   mem_ev;
`else
  logic   unused_mem;
  assign unused_mem = ^{mem_we_i, mem_addr_i, mem_data_i};
`endif

  always_comb begin
    wb_ev    = (state == RUN) && wb_en_i && (wb_addr_i != 5'd0);
    wb_entry = '{kind: TRACE_REG, cycle: cyc, addr: DATA_W'(wb_addr_i), data: wb_data_i};
`ifdef COMMIT_TRACE_MEM_EN
    mem_ev    = (state == RUN) && mem_we_i;
    mem_entry = '{kind: TRACE_MEM, cycle: cyc, addr: mem_addr_i, data: mem_data_i};
    // The writeback always takes the first slot; the store follows it, or
    // takes the first slot itself when it is the only event.
    first_ev     = wb_ev || mem_ev;
    second_ev    = wb_ev && mem_ev;
    first_entry  = wb_ev ? wb_entry : mem_entry;
    second_entry = mem_entry;
`else
    first_ev     = wb_ev;
    second_ev    = 1'b0;
    first_entry  = wb_entry;
    second_entry = '0;
`endif
  end

  assign pop = ev_valid_o && ev_ready_i;

  // A pop on the same edge frees a slot for this edge's pushes.
  always_comb begin
    free     = (CNT_W + 1)'(DEPTH) - {1'b0, count} + (CNT_W + 1)'(pop);
    push0    = first_ev && (free != '0);
    push1    = second_ev && (free >= (CNT_W + 1)'(2));
    drops    = {1'b0, first_ev && !push0} + {1'b0, second_ev && !push1};
    drop_sum = {1'b0, drop_cnt} + 17'(drops);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cyc      <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state <= RUN;
            cyc   <= '0;
          end
        end
        RUN: begin
          cyc <= cyc + 1'b1;
          if (cyc == CYC_W'(MAX_CYCLES - 1)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (count == '0) begin
            state <= DONE;
          end
        end
        default: begin
          state <= DONE;
        end
      endcase

      if (drops != 2'd0) begin
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push0 (push0),
    .data0 (first_entry),
    .push1 (push1),
    .data1 (second_entry),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign head_entry = head;
  assign ev_valid_o = (count != '0);
  assign ev_kind_o  = head_entry.kind;
  assign ev_cycle_o = head_entry.cycle;
  assign ev_addr_o  = head_entry.addr;
  assign ev_data_o  = head_entry.data;
  assign busy_o     = (state == RUN) || (state == DRAIN);
  assign done_o     = (state == DONE);
  assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed, table-driven bench for commit_trace_buffer
// built with DEPTH=4 and the default 30-cycle window. Store expectations
// follow COMMIT_TRACE_MEM_EN.
module tb_commit_trace_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXC  = 30;
  localparam int unsigned CW    = 5;
`ifdef COMMIT_TRACE_MEM_EN
  localparam bit MEM_EN = 1'b1;
`else
  localparam bit MEM_EN = 1'b0;
`endif

  logic          clk, rst, start;
  logic          wb_en;
  logic [4:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          mem_we;
  logic [DW-1:0] mem_addr, mem_data;
  logic          ev_valid, ev_ready, ev_kind;
  logic [CW-1:0] ev_cycle;
  logic [DW-1:0] ev_addr, ev_data;
  logic          busy, done;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int errors = 0;

  commit_trace_buffer #(
    .DATA_W     (DW),
    .DEPTH      (DEPTH),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .wb_en_i    (wb_en),
    .wb_addr_i  (wb_addr),
    .wb_data_i  (wb_data),
    .mem_we_i   (mem_we),
    .mem_addr_i (mem_addr),
    .mem_data_i (mem_data),
    .ev_valid_o (ev_valid),
    .ev_ready_i (ev_ready),
    .ev_kind_o  (ev_kind),
    .ev_cycle_o (ev_cycle),
    .ev_addr_o  (ev_addr),
    .ev_data_o  (ev_data),
    .busy_o     (busy),
    .done_o     (done),
    .drop_cnt_o (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          st, we;
    logic [4:0]    wa;
    logic [DW-1:0] wd;
    logic          mw;
    logic [DW-1:0] ma, md;
    logic          rdy;
    logic          v, k;
    logic [CW-1:0] c;
    logic [DW-1:0] a, d;
    logic          b;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic st, input logic we, input logic [4:0] wa,
                              input logic [DW-1:0] wd, input logic mw,
                              input logic [DW-1:0] ma, input logic [DW-1:0] md,
                              input logic rdy, input logic v, input logic k,
                              input logic [CW-1:0] c, input logic [DW-1:0] a,
                              input logic [DW-1:0] d, input logic b);
    vec_t r;
    r.st = st; r.we = we; r.wa = wa; r.wd = wd; r.mw = mw; r.ma = ma; r.md = md;
    r.rdy = rdy; r.v = v; r.k = k; r.c = c; r.a = a; r.d = d; r.b = b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    mem_we = 1'b0; mem_addr = '0; mem_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic k, input logic [CW-1:0] c,
                          input logic [DW-1:0] a, input logic [DW-1:0] d);
    chk({name, ".valid"}, 64'(ev_valid), 64'(1'b1));
    chk({name, ".kind"},  64'(ev_kind),  64'(k));
    chk({name, ".cycle"}, 64'(ev_cycle), 64'(c));
    chk({name, ".addr"},  64'(ev_addr),  64'(a));
    chk({name, ".data"},  64'(ev_data),  64'(d));
  endtask

  logic [4:0]    exp_a [4];
  logic [CW-1:0] exp_c [4];
  logic [DW-1:0] exp_d [4];

  initial begin
    rst = 1'b0;
    ev_ready = 1'b0;
    idle_inputs();

    //          st we wa  wd           mw ma     md  rdy v       k  c  a      d            busy
    tbl[0]  = mk(1, 0, 0,  0,           0, 0,     0,  1,  0,      0, 0, 0,     0,           1);
    tbl[1]  = mk(0, 1, 0,  99,          0, 0,     0,  1,  0,      0, 0, 0,     0,           1);
    tbl[2]  = mk(0, 0, 0,  0,           0, 0,     0,  1,  0,      0, 0, 0,     0,           1);
    tbl[3]  = mk(1, 1, 0,  99,          0, 0,     0,  1,  0,      0, 0, 0,     0,           1);
    tbl[4]  = mk(0, 1, 5,  7,           0, 0,     0,  1,  1,      0, 3, 5,     7,           1);
    tbl[5]  = mk(0, 1, 1,  1,           1, 'h10,  42, 1,  1,      0, 4, 1,     1,           1);
    tbl[6]  = mk(0, 0, 0,  0,           0, 0,     0,  1,  MEM_EN, 1, 4, 'h10,  42,          1);
    tbl[7]  = mk(0, 0, 0,  0,           0, 0,     0,  1,  0,      0, 0, 0,     0,           1);
    tbl[8]  = mk(0, 1, 0,  3,           1, 'h20,  5,  1,  MEM_EN, 1, 7, 'h20,  5,           1);
    tbl[9]  = mk(0, 1, 31, 'hDEADBEEF,  0, 0,     0,  1,  1,      0, 8, 31,    'hDEADBEEF,  1);
    tbl[10] = mk(0, 0, 0,  0,           0, 0,     0,  0,  1,      0, 8, 31,    'hDEADBEEF,  1);
    tbl[11] = mk(0, 0, 0,  0,           0, 0,     0,  1,  0,      0, 0, 0,     0,           1);

    // Reset state, applied asynchronously between edges.
    #1 rst = 1'b1;
    #2;
    chk("rst.valid", 64'(ev_valid), 64'(1'b0));
    chk("rst.busy",  64'(busy),     64'(1'b0));
    chk("rst.done",  64'(done),     64'(1'b0));
    chk("rst.drop",  64'(drop_cnt), 64'(16'd0));
    chk("rst.data",  64'({ev_kind, ev_cycle, ev_addr, ev_data}), 64'(0));
    step();
    rst = 1'b0;
    step();

    // Start, window stamps, x0 filtering, paired events, back-pressure.
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st; wb_en = tbl[i].we; wb_addr = tbl[i].wa; wb_data = tbl[i].wd;
      mem_we = tbl[i].mw; mem_addr = tbl[i].ma; mem_data = tbl[i].md;
      ev_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d.busy", i),  64'(busy),     64'(tbl[i].b));
      chk($sformatf("vec%0d.valid", i), 64'(ev_valid), 64'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("vec%0d.kind", i),  64'(ev_kind),  64'(tbl[i].k));
        chk($sformatf("vec%0d.cycle", i), 64'(ev_cycle), 64'(tbl[i].c));
        chk($sformatf("vec%0d.addr", i),  64'(ev_addr),  64'(tbl[i].a));
        chk($sformatf("vec%0d.data", i),  64'(ev_data),  64'(tbl[i].d));
      end
    end

    // RUN cycles 11..29 with x0 writes only: nothing logged, then DRAIN.
    idle_inputs();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'd99; ev_ready = 1'b1;
    for (int i = 11; i < int'(MAXC); i++) begin
      step();
      chk($sformatf("x0.cyc%0d.valid", i), 64'(ev_valid), 64'(1'b0));
    end
    chk("drain.busy", 64'(busy), 64'(1'b1));
    chk("drain.done", 64'(done), 64'(1'b0));
    idle_inputs();
    step();
    chk("done.done", 64'(done), 64'(1'b1));
    chk("done.busy", 64'(busy), 64'(1'b0));
    start = 1'b1;
    step();
    start = 1'b0;
    chk("done.hold", 64'(done), 64'(1'b1));
    chk("done.nostart", 64'(busy), 64'(1'b0));

    // Overflow: 6 writes into a 4-deep FIFO with the consumer stalled.
    do_reset();
    ev_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wb_en = 1'b1; wb_addr = 5'(i + 1); wb_data = 32'(101 + i);
      step();
    end
    chk("ovf.drop", 64'(drop_cnt), 64'(16'd2));
    chk_head("ovf.head", 1'b0, 5'd0, 32'd1, 32'd101);
    wb_addr = 5'd8; wb_data = 32'd108;
    mem_we = 1'b1; mem_addr = 32'h40; mem_data = 32'd9;
    step();
    chk("ovf.pair_drop", 64'(drop_cnt), 64'(MEM_EN ? 16'd4 : 16'd3));
    // Full FIFO, pop and push on the same edge: nothing lost.
    mem_we = 1'b0; wb_addr = 5'd7; wb_data = 32'd107; ev_ready = 1'b1;
    step();
    chk("full.pushpop_drop", 64'(drop_cnt), 64'(MEM_EN ? 16'd4 : 16'd3));
    chk_head("full.head", 1'b0, 5'd1, 32'd2, 32'd102);
    idle_inputs();
    exp_a[0] = 5'd3; exp_c[0] = 5'd2; exp_d[0] = 32'd103;
    exp_a[1] = 5'd4; exp_c[1] = 5'd3; exp_d[1] = 32'd104;
    exp_a[2] = 5'd7; exp_c[2] = 5'd7; exp_d[2] = 32'd107;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_head($sformatf("order%0d", i), 1'b0, exp_c[i], 32'(exp_a[i]), exp_d[i]);
    end
    step();
    chk("order.empty", 64'(ev_valid), 64'(1'b0));

    // Reset mid-RUN with entries buffered and drops recorded.
    do_reset();
    ev_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wb_en = 1'b1; wb_addr = 5'(i + 1); wb_data = 32'(i);
      step();
    end
    idle_inputs();
    chk("pre_rst.valid", 64'(ev_valid), 64'(1'b1));
    chk("pre_rst.drop",  64'(drop_cnt), 64'(16'd1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst.valid", 64'(ev_valid), 64'(1'b0));
    chk("mid_rst.busy",  64'(busy),     64'(1'b0));
    chk("mid_rst.drop",  64'(drop_cnt), 64'(16'd0));
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'd9; ev_ready = 1'b1;
    step();
    idle_inputs();
    chk_head("restart", 1'b0, 5'd0, 32'd9, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Synthesizable, parametrised successor to the fixed 30-cycle register/memory dump used in CPU simulation. It snoops the CPU's register-file writeback port and data-memory store port, timestamps each architectural update with a cycle count, and buffers the updates in a FIFO drained over a valid/ready stream. Capture stops after a programmable cycle budget. It sits beside the CPU top, fed from the MEM/WB and EX/MEM stage outputs.

## Interface
- DATA_W, 32, width of register data, store data and store address
- DEPTH, 16, FIFO entries; power of two, minimum 2
- MAX_CYCLES, 30, capture window in cycles after start
- CYC_W, $clog2(MAX_CYCLES+1), cycle-stamp width
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  arms capture when in IDLE
- wb_en_i  in  1  register writeback this cycle
- wb_addr_i  in  5  destination register
- wb_data_i  in  DATA_W  writeback value
- mem_we_i  in  1  data-memory store this cycle
- mem_addr_i  in  DATA_W  store byte address
- mem_data_i  in  DATA_W  store value
- ev_valid_o  out  1  head entry available
- ev_ready_i  in  1  consumer accepts head
- ev_kind_o  out  1  0 = register write, 1 = store
- ev_cycle_o  out  CYC_W  cycle stamp of the event
- ev_addr_o  out  DATA_W  register index (zero-extended) or store address
- ev_data_o  out  DATA_W  written value
- busy_o  out  1  state is RUN or DRAIN
- done_o  out  1  state is DONE
- drop_cnt_o  out  16  saturating count of dropped events

## Operation
- FSM: IDLE -> RUN when start_i=1. RUN -> DRAIN on the cycle where cycle count == MAX_CYCLES-1, after that cycle's capture. DRAIN -> DONE when the FIFO is empty. DONE holds until reset. start_i is ignored outside IDLE.
- Cycle counter clears on IDLE->RUN and increments each RUN cycle. The first RUN cycle is stamped 0.
- Capture happens only in RUN. A wb event requires wb_en_i=1 and wb_addr_i!=0; writes to x0 are never logged. A store event requires mem_we_i=1.
- A wb event and a store event in the same cycle push two entries in one edge: the wb entry first, then the store entry.
- Free space for the edge = DEPTH - count + (ev_valid_o & ev_ready_i). Entries are pushed in priority order while space remains. Each entry that does not fit is dropped and drop_cnt_o increases by 1 or 2, saturating at 0xFFFF.
- Pop happens when ev_valid_o & ev_ready_i. Push and pop in the same edge are legal, including when the FIFO is full.
- Output fields hold the head entry and are valid whenever ev_valid_o=1. When ev_valid_o=0 they are don't-care.

## Timing
- Reset values: ev_valid_o=0, busy_o=0, done_o=0, drop_cnt_o=0, state IDLE, FIFO empty, counter 0. The ev_* data outputs reset to 0.
- Latency: an event sampled at edge N appears at the head after edge N, provided the FIFO is empty and no older entry is present.
- busy_o rises the edge after start_i is sampled in IDLE. done_o rises the edge after the pop that empties the FIFO in DRAIN, or immediately after entering DRAIN if the FIFO is already empty.
- Reset asserted mid-operation clears all state immediately, including buffered entries. It does not wait for a clock edge.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.

## Configuration
- COMMIT_TRACE_MEM_EN defined: store capture as described.
- COMMIT_TRACE_MEM_EN undefined: the mem_* inputs are ignored and ev_kind_o is tied to 0. The FIFO has a single push port and at most one event per cycle. The ports remain present.

## Structure
- Package trace_pkg holds: the kind constants (TRACE_REG=1'b0, TRACE_MEM=1'b1), the state encoding (IDLE, RUN, DRAIN, DONE), and the packed entry struct {kind, cycle, addr, data}.
- Sub-module trace_fifo holds the dual-push, single-pop FIFO (DEPTH and entry width as parameters, exposing count). The FSM, counters and drop logic stay in commit_trace_buffer.

## Test plan
- Reset, start, wb x5=7 on RUN cycle 3, ready=1 -> one entry {0,3,5,7}; after MAX_CYCLES, done_o=1.
- wb x0=99 on every cycle -> no entries; done_o=1 after 30 RUN cycles plus 1.
- Same cycle 4: wb x1=1 and store [0x10]=42 -> entries {0,4,1,1} then {1,4,0x10,42}. With the macro off, only the first entry appears.
- DEPTH=4, ready=0, one wb per cycle for 6 cycles -> 4 entries kept, drop_cnt_o=2. Releasing ready drains them in order, then done_o=1.
- FIFO full with ready=1 and a simultaneous push -> no drop; count stays at DEPTH.
- rst_i pulsed mid-RUN with 3 entries buffered -> ev_valid_o=0, busy_o=0 and drop_cnt_o=0 before the next edge. A new start restarts stamps at 0.
